qnigma_alu_ext_port: RTL and testbench
======================================

# qnigma_alu_ext_port

Responder side of the ALU external word-serial access interface. It accepts operand writes (`ext_wr_*`) and serves result reads (`ext_rd_*`) issued by an external client such as a test wrapper or key-exchange sequencer. It translates both into accesses on the ALU operand RAM through a single shared registered port. It sits between the client and the RAM, next to the ALU core, and is locked out while the core runs a task.

## Interface
- `WRD_W`, 32: RAM word width.
- `PTR_W`, 8: operand base pointer width, equal to the RAM address width.
- `WORDS_25519`, 8: words per F25519 operand.
- `WORDS_1305`, 5: words per F1305 operand.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `ext_wr_dat`  in  WRD_W  write word.
- `ext_wr_ptr`  in  PTR_W  operand base address, sampled with `ext_wr_sof`.
- `ext_wr_val`  in  1  write word valid.
- `ext_wr_sof`  in  1  first (most-significant) word of an operand. Qualified by `ext_wr_val`.
- `ext_wr_fld`  in  1  field, sampled with sof: 1 = F25519, 0 = F1305.
- `ext_rd_req`  in  1  read request. Level signal, held for the whole read.
- `ext_rd_nxt`  in  1  continue issuing words.
- `ext_rd_ptr`  in  PTR_W  read base address, sampled on the rising edge of `ext_rd_req`.
- `ext_rd_fld`  in  1  read field, sampled with `ext_rd_ptr`.
- `ext_rd_dat`  out  WRD_W  read word.
- `ext_rd_val`  out  1  read word valid.
- `ext_rd_eof`  out  1  marks the last word. Asserted together with `ext_rd_val`.
- `alu_bsy`  in  1  ALU core owns the RAM.
- `ram_addr`  out  PTR_W  RAM address. Registered.
- `ram_wen`  out  1  RAM write enable. Registered.
- `ram_wdat`  out  WRD_W  RAM write data. Registered.
- `ram_ren`  out  1  RAM read enable. Registered.
- `ram_rdat`  in  WRD_W  RAM read data. Valid the cycle after `ram_ren`.
- `ext_err`  out  1  sticky protocol error. Cleared only by `rst`.

## Operation
- Word count: N = `WORDS_25519` if fld = 1, otherwise `WORDS_1305`. Words travel most-significant first.
- Addressing: address = ptr + idx, modulo 2^PTR_W, where idx runs from N-1 down to 0.
- Write FSM has two states, W_IDLE and W_ACT.
  - sof & val: latch ptr and fld, set idx = N-1, write the word, go to W_ACT. The word count is N-1 remaining.
  - In W_ACT, each val without sof writes at the next lower idx. Return to W_IDLE after idx 0 is written.
  - sof while in W_ACT restarts the operand. This is not an error.
  - Write is dropped and `ext_err` is set for: val without sof in W_IDLE; any val while `alu_bsy`=1.
- Read FSM states: R_IDLE, R_ISS, R_DRN, R_HOLD.
  - R_IDLE, on `ext_rd_req` rising (req=1, previous req=0): latch ptr and fld, set issue count to N, go to R_ISS.
  - R_ISS: issue one read per cycle. The first word is issued unconditionally; later words issue only when `ext_rd_nxt`=1. After N issues go to R_DRN.
  - R_DRN: wait for the last word to reach the output, then go to R_HOLD.
  - R_HOLD: stay until req=0, then go to R_IDLE. No further `ext_rd_val` in this state.
- Arbitration on the shared port:
  - A write wins over a read issue in the same cycle. The read issue slips one cycle and no word is lost.
  - `alu_bsy`=1 suppresses all read issues. Words already issued still complete.
- Responder data path: each `ram_ren` produces exactly one `ext_rd_val` two cycles later, with `ext_rd_dat` = `ram_rdat`. `ext_rd_eof` is asserted on the word at idx 0.
- If req drops during R_ISS or R_DRN, issuing stops and in-flight words are discarded (no val). The FSM returns to R_IDLE.
- Reset mid-operation: both FSMs return to idle and every output goes to 0.

## Timing
- Reset values: all outputs are 0, including `ram_*`, `ext_rd_*` and `ext_err`.
- Write latency: val sampled at edge k gives `ram_wen`=1 with address and data during cycle k+1.
- Read latency: req first sampled high at edge k.
  - `ram_ren` is high in cycle k+1.
  - `ext_rd_val` is high in cycle k+3.
  - Back-to-back words follow every cycle while `ext_rd_nxt`=1 and there is no conflict.
- `ext_rd_val` gaps are legal. Clients count valid words, not cycles.
- Simultaneous write and read are serialized exactly as in the arbitration rule above.

## Test plan
- F25519 write then read: write 8 words 0x11111111..0x88888888 at ptr 50, then read ptr 50 with nxt tied to req delayed one cycle. Required: 8 vals, MS word 0x11111111 first; eof only on 0x88888888; first val 3 cycles after req; `ext_err`=0.
- F1305 read at ptr 74: 5 vals on consecutive cycles, eof on the 5th; addresses 78 down to 74; no 6th val while req is held.
- Wrap-around: write an F25519 operand at ptr 252. Required: `ram_addr` sequence 3, 2, 1, 0, 255, 254, 253, 252.
- Conflict: a write val in the same cycle as the 3rd read issue. Required: `ram_wen` that cycle, read issue deferred one cycle, all 8 read words correct and in order.
- Errors:
  - val without sof gives no `ram_wen` and `ext_err`=1, sticky.
  - With `alu_bsy`=1 during a read, no `ram_ren`; words resume after bsy falls.
- Reset mid-read after 3 vals: outputs 0 the next cycle. A fresh req afterwards returns all N words from idx N-1.

Source files
------------

// File: rtl/qnigma_alu_ext_port.sv
// qnigma_alu_ext_port
// Responder for the ALU external word-serial access interface. Operand writes
// and result reads from an external client are turned into accesses on the
// single registered port of the ALU operand RAM. Words travel most-significant
// first, i.e. from index N-1 down to index 0 relative to the operand base.
module qnigma_alu_ext_port #(
    parameter int WRD_W       = 32,
    parameter int PTR_W       = 8,
    parameter int WORDS_25519 = 8,
    parameter int WORDS_1305  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WRD_W-1:0] ext_wr_dat,
    input  logic [PTR_W-1:0] ext_wr_ptr,
    input  logic             ext_wr_val,
    input  logic             ext_wr_sof,
    input  logic             ext_wr_fld,
    input  logic             ext_rd_req,
    input  logic             ext_rd_nxt,
    input  logic [PTR_W-1:0] ext_rd_ptr,
    input  logic             ext_rd_fld,
    output logic [WRD_W-1:0] ext_rd_dat,
    output logic             ext_rd_val,
    output logic             ext_rd_eof,
    input  logic             alu_bsy,
    output logic [PTR_W-1:0] ram_addr,
    output logic             ram_wen,
    output logic [WRD_W-1:0] ram_wdat,
    output logic             ram_ren,
    input  logic [WRD_W-1:0] ram_rdat,
    output logic             ext_err
);

    localparam logic       W_IDLE = 1'b0;
    localparam logic       W_ACT  = 1'b1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ISS  = 2'd1;
    localparam logic [1:0] R_DRN  = 2'd2;
    localparam logic [1:0] R_HOLD = 2'd3;

    localparam logic [PTR_W-1:0] N_25519 = PTR_W'(WORDS_25519);
    localparam logic [PTR_W-1:0] N_1305  = PTR_W'(WORDS_1305);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    // Write side: w_idx_q is the index the next non-sof word lands on.
    logic             w_state_q, w_state_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0] w_idx_q, w_idx_d;
    logic             err_q, err_d;

    // Read side: r_cnt_q counts issues still owed; r_first_q lets the first
    // word go out without ext_rd_nxt.
    logic [1:0]       r_state_q, r_state_d;
    logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
    logic [PTR_W-1:0] r_cnt_q, r_cnt_d;
    logic             r_first_q, r_first_d;
    logic             req_prev_q;

    // Read return pipeline: RAM read stage, RAM data stage, output stage.
    logic             ren_eof_q, ren_eof_d;
    logic             p1_vld_q, p1_vld_d;
    logic             p1_eof_q, p1_eof_d;
    logic             rd_val_q, rd_val_d;
    logic             rd_eof_q, rd_eof_d;
    logic [WRD_W-1:0] rd_dat_q, rd_dat_d;

    // Registered RAM port.
    logic [PTR_W-1:0] ram_addr_q, ram_addr_d;
    logic             ram_wen_q, ram_wen_d;
    logic [WRD_W-1:0] ram_wdat_q, ram_wdat_d;
    logic             ram_ren_q, ram_ren_d;

    logic             wr_go;
    logic [PTR_W-1:0] wr_n;
    logic [PTR_W-1:0] w_addr;
    logic             rd_start;
    logic [PTR_W-1:0] act_ptr;
    logic [PTR_W-1:0] act_cnt;
    logic             act_first;
    logic             rd_go;
    logic [PTR_W-1:0] r_addr;
    logic             flush;

    // Write FSM: accept operand words, flag protocol violations.
    always_comb begin
        wr_go     = 1'b0;
        w_addr    = '0;
        w_state_d = w_state_q;
        w_ptr_d   = w_ptr_q;
        w_idx_d   = w_idx_q;
        err_d     = err_q;
        wr_n      = ext_wr_fld ? N_25519 : N_1305;
        if (ext_wr_val) begin
            if (alu_bsy) begin
                err_d = 1'b1;
            end else if (ext_wr_sof) begin
                // sof always (re)starts an operand, even mid-operand
                wr_go     = 1'b1;
                w_addr    = ext_wr_ptr + wr_n - ONE;
                w_ptr_d   = ext_wr_ptr;
                w_idx_d   = wr_n - PTR_W'(2);
                w_state_d = (wr_n == ONE) ? W_IDLE : W_ACT;
            end else if (w_state_q == W_ACT) begin
                wr_go  = 1'b1;
                w_addr = w_ptr_q + w_idx_q;
                if (w_idx_q == '0) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_idx_d = w_idx_q - ONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Read FSM: a rising req issues its first word in the same cycle, so the
    // issue logic works on the "effective" context (fresh or latched).
    always_comb begin
        rd_start  = (r_state_q == R_IDLE) && ext_rd_req && !req_prev_q;
        act_ptr   = rd_start ? ext_rd_ptr : r_ptr_q;
        act_cnt   = rd_start ? (ext_rd_fld ? N_25519 : N_1305) : r_cnt_q;
        act_first = rd_start || r_first_q;
        rd_go     = (rd_start || (r_state_q == R_ISS)) && ext_rd_req &&
                    (act_first || ext_rd_nxt) && !wr_go && !alu_bsy;
        r_addr    = act_ptr + act_cnt - ONE;
        flush     = !ext_rd_req && ((r_state_q == R_ISS) || (r_state_q == R_DRN));

        r_state_d = r_state_q;
        r_ptr_d   = r_ptr_q;
        r_cnt_d   = r_cnt_q;
        r_first_d = r_first_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_start) begin
                    r_ptr_d   = ext_rd_ptr;
                    r_cnt_d   = act_cnt;
                    r_first_d = 1'b1;
                    r_state_d = R_ISS;
                end
            end
            R_ISS: begin
                if (!ext_rd_req) r_state_d = R_IDLE;
            end
            R_DRN: begin
                if (!ext_rd_req)                r_state_d = R_IDLE;
                else if (rd_val_q && rd_eof_q)  r_state_d = R_HOLD;
            end
            default: begin
                if (!ext_rd_req) r_state_d = R_IDLE;
            end
        endcase
        if (rd_go) begin
            r_cnt_d   = act_cnt - ONE;
            r_first_d = 1'b0;
            if (act_cnt == ONE) r_state_d = R_DRN;
        end
    end

    // RAM port and return pipeline; an aborted read drops its in-flight words.
    always_comb begin
        ram_wen_d  = wr_go;
        ram_ren_d  = rd_go;
        ram_wdat_d = wr_go ? ext_wr_dat : ram_wdat_q;
        ram_addr_d = wr_go ? w_addr : (rd_go ? r_addr : ram_addr_q);
        ren_eof_d  = rd_go && (act_cnt == ONE);
        p1_vld_d   = ram_ren_q && !flush;
        p1_eof_d   = ren_eof_q;
        rd_val_d   = p1_vld_q && !flush;
        rd_eof_d   = p1_vld_q && p1_eof_q && !flush;
        rd_dat_d   = (p1_vld_q && !flush) ? ram_rdat : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            w_ptr_q    <= '0;
            w_idx_q    <= '0;
            err_q      <= 1'b0;
            r_state_q  <= R_IDLE;
            r_ptr_q    <= '0;
            r_cnt_q    <= '0;
            r_first_q  <= 1'b0;
            req_prev_q <= 1'b0;
            ren_eof_q  <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_eof_q   <= 1'b0;
            rd_val_q   <= 1'b0;
            rd_eof_q   <= 1'b0;
            rd_dat_q   <= '0;
            ram_addr_q <= '0;
            ram_wen_q  <= 1'b0;
            ram_wdat_q <= '0;
            ram_ren_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            w_ptr_q    <= w_ptr_d;
            w_idx_q    <= w_idx_d;
            err_q      <= err_d;
            r_state_q  <= r_state_d;
            r_ptr_q    <= r_ptr_d;
            r_cnt_q    <= r_cnt_d;
            r_first_q  <= r_first_d;
            req_prev_q <= ext_rd_req;
            ren_eof_q  <= ren_eof_d;
            p1_vld_q   <= p1_vld_d;
            p1_eof_q   <= p1_eof_d;
            rd_val_q   <= rd_val_d;
            rd_eof_q   <= rd_eof_d;
            rd_dat_q   <= rd_dat_d;
            ram_addr_q <= ram_addr_d;
            ram_wen_q  <= ram_wen_d;
            ram_wdat_q <= ram_wdat_d;
            ram_ren_q  <= ram_ren_d;
        end
    end

    assign ext_rd_dat = rd_dat_q;
    assign ext_rd_val = rd_val_q;
    assign ext_rd_eof = rd_eof_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wen    = ram_wen_q;
    assign ram_wdat   = ram_wdat_q;
    assign ram_ren    = ram_ren_q;
    assign ext_err    = err_q;

endmodule

// File: tb/tb_qnigma_alu_ext_port.sv
// Directed bench for qnigma_alu_ext_port with a registered-read RAM model.
module tb_qnigma_alu_ext_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ext_wr_dat;
    logic [7:0]  ext_wr_ptr;
    logic        ext_wr_val, ext_wr_sof, ext_wr_fld;
    logic        ext_rd_req, ext_rd_nxt;
    logic [7:0]  ext_rd_ptr;
    logic        ext_rd_fld;
    logic [31:0] ext_rd_dat;
    logic        ext_rd_val, ext_rd_eof;
    logic        alu_bsy;
    logic [7:0]  ram_addr;
    logic        ram_wen, ram_ren;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat = '0;
    logic        ext_err;

    qnigma_alu_ext_port dut (
        .clk(clk), .rst(rst),
        .ext_wr_dat(ext_wr_dat), .ext_wr_ptr(ext_wr_ptr), .ext_wr_val(ext_wr_val),
        .ext_wr_sof(ext_wr_sof), .ext_wr_fld(ext_wr_fld),
        .ext_rd_req(ext_rd_req), .ext_rd_nxt(ext_rd_nxt), .ext_rd_ptr(ext_rd_ptr),
        .ext_rd_fld(ext_rd_fld), .ext_rd_dat(ext_rd_dat), .ext_rd_val(ext_rd_val),
        .ext_rd_eof(ext_rd_eof), .alu_bsy(alu_bsy), .ram_addr(ram_addr),
        .ram_wen(ram_wen), .ram_wdat(ram_wdat), .ram_ren(ram_ren),
        .ram_rdat(ram_rdat), .ext_err(ext_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write and registered read
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_wdat;
        if (ram_ren) ram_rdat <= mem[ram_addr];
    end

    // Observation queues, filled on the falling edge
    logic [31:0] rd_dat_q[$];
    logic        rd_eof_q[$];
    int          rd_cyc_q[$];
    logic [7:0]  wen_addr_q[$];
    int          wen_cyc_q[$];
    logic [7:0]  ren_addr_q[$];
    int          ren_cyc_q[$];

    always @(negedge clk) begin
        if (ext_rd_val) begin
            rd_dat_q.push_back(ext_rd_dat);
            rd_eof_q.push_back(ext_rd_eof);
            rd_cyc_q.push_back(cyc);
        end
        if (ram_wen) begin
            wen_addr_q.push_back(ram_addr);
            wen_cyc_q.push_back(cyc);
        end
        if (ram_ren) begin
            ren_addr_q.push_back(ram_addr);
            ren_cyc_q.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] wbuf  [8];
    logic [31:0] exp_w [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_dat_q.delete(); rd_eof_q.delete(); rd_cyc_q.delete();
        wen_addr_q.delete(); wen_cyc_q.delete();
        ren_addr_q.delete(); ren_cyc_q.delete();
    endtask

    task automatic write_op(input logic [7:0] ptr, input logic fld, input int n);
        for (int i = 0; i < n; i++) begin
            ext_wr_val = 1'b1;
            ext_wr_sof = (i == 0);
            ext_wr_ptr = ptr;
            ext_wr_fld = fld;
            ext_wr_dat = wbuf[i];
            tick();
        end
        ext_wr_val = 1'b0;
        ext_wr_sof = 1'b0;
        tick();
        $display("wr ptr=%0d fld=%0d words=%0d", ptr, fld, n);
    endtask

    task automatic read_op(input logic [7:0] ptr, input logic fld, input bit nxt_late,
                           input int hold, output int t_req);
        ext_rd_req = 1'b1;
        ext_rd_ptr = ptr;
        ext_rd_fld = fld;
        ext_rd_nxt = !nxt_late;
        t_req      = cyc;
        for (int i = 0; i < hold; i++) begin
            tick();
            ext_rd_nxt = 1'b1;
        end
        ext_rd_req = 1'b0;
        ext_rd_nxt = 1'b0;
        tick();
        tick();
        $display("rd ptr=%0d fld=%0d vals=%0d", ptr, fld, rd_dat_q.size());
    endtask

    task automatic check_words(input string tag, input int n);
        chk({tag, "_cnt"}, rd_dat_q.size(), n);
        for (int i = 0; i < n && i < rd_dat_q.size(); i++) begin
            chk($sformatf("%s_dat%0d", tag, i), rd_dat_q[i], exp_w[i]);
            chk($sformatf("%s_eof%0d", tag, i), {31'd0, rd_eof_q[i]}, {31'd0, (i == n - 1)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int budget;
        rst = 1'b1;
        ext_wr_dat = '0; ext_wr_ptr = '0; ext_wr_val = 1'b0; ext_wr_sof = 1'b0;
        ext_wr_fld = 1'b0; ext_rd_req = 1'b0; ext_rd_nxt = 1'b0; ext_rd_ptr = '0;
        ext_rd_fld = 1'b0; alu_bsy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_flags", {27'd0, ram_wen, ram_ren, ext_rd_val, ext_rd_eof, ext_err}, 32'd0);
        chk("reset_addr", {24'd0, ram_addr}, 32'd0);
        chk("reset_rdat", ext_rd_dat, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // F25519 write then read at ptr 50, nxt one cycle behind req
        for (int i = 0; i < 8; i++) begin
            wbuf[i]  = 32'h11111111 * (i + 1);
            exp_w[i] = 32'h11111111 * (i + 1);
        end
        clr();
        write_op(8'd50, 1'b1, 8);
        chk("wr50_cnt", wen_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < wen_addr_q.size(); i++)
            chk($sformatf("wr50_addr%0d", i), {24'd0, wen_addr_q[i]}, 57 - i);
        clr();
        read_op(8'd50, 1'b1, 1'b1, 20, t0);
        check_words("rd50", 8);
        if (rd_cyc_q.size() > 0) chk("rd50_lat", rd_cyc_q[0] - t0, 3);
        else                     chk("rd50_lat", 32'hFFFFFFFF, 3);
        chk("rd50_err", {31'd0, ext_err}, 0);

        // F1305 at ptr 74: consecutive words, addresses 78..74, no extra val
        for (int i = 0; i < 5; i++) begin
            wbuf[i]  = 32'hA0000000 + i;
            exp_w[i] = 32'hA0000000 + i;
        end
        write_op(8'd74, 1'b0, 5);
        clr();
        read_op(8'd74, 1'b0, 1'b0, 20, t0);
        check_words("rd74", 5);
        for (int i = 0; i < 5 && i < rd_cyc_q.size(); i++)
            chk($sformatf("rd74_cyc%0d", i), rd_cyc_q[i] - t0, 3 + i);
        chk("rd74_ren_cnt", ren_addr_q.size(), 5);
        for (int i = 0; i < 5 && i < ren_addr_q.size(); i++)
            chk($sformatf("rd74_addr%0d", i), {24'd0, ren_addr_q[i]}, 78 - i);

        // Wrap-around write at ptr 252
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE0000 + i;
        clr();
        write_op(8'd252, 1'b1, 8);
        chk("wrap_cnt", wen_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < wen_addr_q.size(); i++)
            chk($sformatf("wrap_addr%0d", i), {24'd0, wen_addr_q[i]}, (259 - i) % 256);

        // Protocol error: val without sof while idle
        clr();
        ext_wr_val = 1'b1; ext_wr_sof = 1'b0; ext_wr_ptr = 8'd10; ext_wr_dat = 32'h0BAD0BAD;
        tick();
        ext_wr_val = 1'b0;
        tick(); tick();
        $display("wr orphan word");
        chk("err_nowen", wen_addr_q.size(), 0);
        chk("err_set", {31'd0, ext_err}, 1);
        repeat (3) tick();
        chk("err_sticky", {31'd0, ext_err}, 1);

        // alu_bsy holds off issues; words resume once it drops
        for (int i = 0; i < 8; i++) exp_w[i] = 32'h11111111 * (i + 1);
        clr();
        alu_bsy = 1'b1;
        ext_rd_req = 1'b1; ext_rd_ptr = 8'd50; ext_rd_fld = 1'b1; ext_rd_nxt = 1'b1;
        t0 = cyc;
        repeat (6) tick();
        chk("bsy_noren", ren_addr_q.size(), 0);
        chk("bsy_noval", rd_dat_q.size(), 0);
        alu_bsy = 1'b0;
        repeat (15) tick();
        ext_rd_req = 1'b0; ext_rd_nxt = 1'b0;
        tick(); tick();
        $display("rd bsy ptr=50 vals=%0d", rd_dat_q.size());
        check_words("bsy", 8);
        if (ren_cyc_q.size() > 0) chk("bsy_resume", ren_cyc_q[0] - t0, 7);
        else                      chk("bsy_resume", 32'hFFFFFFFF, 7);

        // Write collides with the 3rd read issue
        clr();
        ext_rd_req = 1'b1; ext_rd_ptr = 8'd50; ext_rd_fld = 1'b1; ext_rd_nxt = 1'b1;
        t0 = cyc;
        tick(); tick();
        ext_wr_val = 1'b1; ext_wr_sof = 1'b1; ext_wr_ptr = 8'd100; ext_wr_fld = 1'b0;
        ext_wr_dat = 32'hDEADBEEF;
        tick();
        ext_wr_val = 1'b0; ext_wr_sof = 1'b0;
        repeat (15) tick();
        ext_rd_req = 1'b0; ext_rd_nxt = 1'b0;
        tick(); tick();
        $display("rd conflict ptr=50 vals=%0d wen=%0d", rd_dat_q.size(), wen_addr_q.size());
        chk("cfl_wen_cnt", wen_addr_q.size(), 1);
        if (wen_addr_q.size() > 0) begin
            chk("cfl_wen_cyc", wen_cyc_q[0] - t0, 3);
            chk("cfl_wen_addr", {24'd0, wen_addr_q[0]}, 104);
        end
        chk("cfl_ren_cnt", ren_cyc_q.size(), 8);
        for (int i = 0; i < 8 && i < ren_cyc_q.size(); i++)
            chk($sformatf("cfl_ren_cyc%0d", i), ren_cyc_q[i] - t0, (i < 2) ? i + 1 : i + 2);
        check_words("cfl", 8);

        // Reset after the 3rd word, then a fresh full read
        clr();
        ext_rd_req = 1'b1; ext_rd_ptr = 8'd50; ext_rd_fld = 1'b1; ext_rd_nxt = 1'b1;
        budget = 40;
        while (rd_dat_q.size() < 3 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        chk("rstmid_pre", rd_dat_q.size(), 3);
        rst = 1'b1;
        ext_rd_req = 1'b0; ext_rd_nxt = 1'b0;
        @(negedge clk);
        chk("rstmid_flags", {27'd0, ram_wen, ram_ren, ext_rd_val, ext_rd_eof, ext_err}, 32'd0);
        chk("rstmid_addr", {24'd0, ram_addr}, 32'd0);
        chk("rstmid_wdat", ram_wdat, 32'd0);
        chk("rstmid_rdat", ext_rd_dat, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        $display("rd reset after vals=%0d", rd_dat_q.size());
        chk("rstmid_cnt", rd_dat_q.size(), 3);
        clr();
        read_op(8'd50, 1'b1, 1'b0, 20, t0);
        check_words("fresh", 8);
        if (ren_addr_q.size() > 0) chk("fresh_addr0", {24'd0, ren_addr_q[0]}, 57);
        else                       chk("fresh_addr0", 32'hFFFFFFFF, 57);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
